// File: rtl/spi_adc_responder.sv
// rtl/spi_adc_responder.sv - SPI mode-0 slave emulating a 4-channel ADC for HIL
//
// Ports:
//   clk_100mhz   system clock
//   rst_n        asynchronous active-low reset
//   spi_sck      SPI clock from master (mode 0, asynchronous)
//   spi_mosi     command bits, MSB first
//   spi_cs_n     frame select, active low
//   spi_miso     sample bits, MSB first, always driven
//   sample_data  four channel samples, ch0 in the low slice
//   sample_load  strobe capturing sample_data into the hold registers
//   frame_done   pulse at the end of a complete, valid frame
//   frame_err    pulse on a short frame or an invalid command
//   cmd_ch       channel of the last valid frame
//   busy         high while a frame is active
module spi_adc_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_n,
    input  logic                    spi_sck,
    input  logic                    spi_mosi,
    input  logic                    spi_cs_n,
    output logic                    spi_miso,
    input  logic [4*DATA_WIDTH-1:0] sample_data,
    input  logic                    sample_load,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic [1:0]              cmd_ch,
    output logic                    busy
);

    localparam int CW = $clog2(DATA_WIDTH + 9);
    localparam logic [CW-1:0] CMD_LAST  = CW'(7);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]  sck_sync, mosi_sync, cs_sync, flush_sr;
    logic                    sck_d, cs_d, armed;
    logic                    sck_s, mosi_s, cs_s;
    logic                    sck_rise, sck_fall, cs_rise, cs_fall;
    logic [4*DATA_WIDTH-1:0] hold_q, shadow_q;
    logic [6:0]              cmd_sr;
    logic [DATA_WIDTH-1:0]   shift_sr;
    logic [CW-1:0]           bit_cnt;
    logic                    cmd_valid;
    logic [1:0]              ch_sel;
    logic                    start_frame, cmd_last, data_last;
    logic                    done_d, err_d;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;

    // Channel bits of the command as they complete on the 8th rising edge.
    assign ch_sel = {cmd_sr[0], mosi_s};

    assign start_frame = (state_q == IDLE) && cs_fall && armed;
    assign cmd_last    = (state_q == CMD) && sck_rise && !cs_rise && (bit_cnt == CMD_LAST);
    assign data_last   = (state_q == DATA) && sck_rise && !cs_rise && (bit_cnt == DATA_LAST);

    // Synchronizers reset to idle line levels. flush_sr marks when the
    // chain holds real pin samples; armed then requires cs_n to be seen
    // high, so a frame already in progress at reset release is ignored.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            flush_sr  <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            flush_sr  <= {flush_sr[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
            armed     <= armed | (flush_sr[SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_frame) state_d = CMD;
            CMD:     if (cs_rise) state_d = IDLE;
                     else if (cmd_last) state_d = DATA;
            DATA:    if (cs_rise) state_d = IDLE;
                     else if (data_last) state_d = WAIT_CS;
            WAIT_CS: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done_d = (state_q == WAIT_CS) && cs_rise && cmd_valid;
        err_d  = ((state_q == CMD || state_q == DATA) && cs_rise) ||
                 (cmd_last && !cmd_sr[6]);
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            shadow_q   <= '0;
            cmd_sr     <= '0;
            shift_sr   <= '0;
            bit_cnt    <= '0;
            cmd_valid  <= 1'b0;
            spi_miso   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            cmd_ch     <= 2'd0;
        end else begin
            if (sample_load) hold_q <= sample_data;
            frame_done <= done_d;
            frame_err  <= err_d;
            if (done_d) cmd_ch <= cmd_sr[1:0];

            case (state_q)
                IDLE: begin
                    if (start_frame) begin
                        // A load in the same cycle wins over the stale hold value.
                        shadow_q  <= sample_load ? sample_data : hold_q;
                        bit_cnt   <= '0;
                        cmd_valid <= 1'b0;
                    end
                end
                CMD: begin
                    if (sck_rise && !cs_rise) begin
                        cmd_sr <= {cmd_sr[5:0], mosi_s};
                        if (bit_cnt == CMD_LAST) begin
                            bit_cnt   <= '0;
                            cmd_valid <= cmd_sr[6];
                            shift_sr  <= cmd_sr[6] ?
                                shadow_q[int'(ch_sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        spi_miso <= shift_sr[DATA_WIDTH-1];
                        shift_sr <= {shift_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (sck_rise) bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase

            if (state_d != DATA) spi_miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// tb/tb_spi_adc_responder.sv - directed table-driven bench for spi_adc_responder
module tb_spi_adc_responder;

    localparam int DW = 16;

    logic            clk_100mhz = 1'b0;
    logic            rst_n = 1'b0;
    logic            spi_sck = 1'b0;
    logic            spi_mosi = 1'b0;
    logic            spi_cs_n = 1'b1;
    logic            sample_load = 1'b0;
    logic [4*DW-1:0] sample_data = '0;
    logic            spi_miso, frame_done, frame_err, busy;
    logic [1:0]      cmd_ch;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    logic done_busy_overlap = 1'b0;

    spi_adc_responder #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .sample_data(sample_data),
        .sample_load(sample_load),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .cmd_ch     (cmd_ch),
        .busy       (busy)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(negedge clk_100mhz) begin
        if (frame_done) begin
            done_cnt++;
            if (busy) done_busy_overlap = 1'b1;
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_all(input logic [4*DW-1:0] v);
        @(negedge clk_100mhz);
        sample_data = v;
        sample_load = 1'b1;
        @(negedge clk_100mhz);
        sample_load = 1'b0;
    endtask

    // 10 MHz master: miso is sampled just before each sck rising edge.
    task automatic spi_frame(input logic [7:0] cmd, input int ncyc, input bit coload,
                             input logic [4*DW-1:0] co_data, output logic [DW-1:0] data,
                             output logic [7:0] cmd_miso, output logic extra_nz,
                             output int err_at8, output logic busy_mid);
        int e0;
        e0 = err_cnt;
        data = '0; cmd_miso = '0; extra_nz = 1'b0; err_at8 = 0; busy_mid = 1'b0;
        @(negedge clk_100mhz);
        spi_cs_n = 1'b0;
        if (coload) begin
            @(negedge clk_100mhz);
            @(negedge clk_100mhz);
            sample_data = co_data;
            sample_load = 1'b1;
            @(negedge clk_100mhz);
            sample_load = 1'b0;
        end
        #50;
        for (int i = 0; i < ncyc; i++) begin
            spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
            #50;
            if (i < 8) cmd_miso = {cmd_miso[6:0], spi_miso};
            else if (i < 8 + DW) data = {data[DW-2:0], spi_miso};
            else extra_nz = extra_nz | spi_miso;
            if (i == 8) err_at8 = err_cnt - e0;
            if (i == 4) busy_mid = busy;
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
        #50;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #300;
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          ncyc;
        bit          chk_data;
        logic [15:0] exp_data;
        int          exp_done;
        int          exp_err;
        int          exp_err8;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t            vecs[6];
    logic [4*DW-1:0] sd;
    logic [DW-1:0]   data;
    logic [7:0]      cmd_miso;
    logic            extra_nz, busy_mid, any_busy;
    int              err8, d0, e0;

    initial begin
        vecs[0] = '{8'h82, 24, 1'b1, 16'hA5C3, 1, 0, 0, 2'd2};
        vecs[1] = '{8'h83, 30, 1'b1, 16'h8001, 1, 0, 0, 2'd3};
        vecs[2] = '{8'h03, 24, 1'b1, 16'h0000, 0, 1, 1, 2'd3};
        vecs[3] = '{8'h81, 12, 1'b0, 16'h0000, 0, 1, 0, 2'd3};
        vecs[4] = '{8'h81, 24, 1'b1, 16'h5A0F, 1, 0, 0, 2'd1};
        vecs[5] = '{8'hFC, 24, 1'b1, 16'h1234, 1, 0, 0, 2'd0};
        sd = {16'h8001, 16'hA5C3, 16'h5A0F, 16'h1234};

        #33;
        check("reset_miso", {31'd0, spi_miso}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, frame_done}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        check("reset_cmd_ch", {30'd0, cmd_ch}, 32'd0);
        #17;
        rst_n = 1'b1;
        #100;
        load_all(sd);

        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            spi_frame(vecs[v].cmd, vecs[v].ncyc, 1'b0, '0, data, cmd_miso, extra_nz, err8, busy_mid);
            if (vecs[v].chk_data) check($sformatf("v%0d_data", v), {16'd0, data}, {16'd0, vecs[v].exp_data});
            if (vecs[v].ncyc > 8 + DW) check($sformatf("v%0d_extra_miso", v), {31'd0, extra_nz}, 32'd0);
            check($sformatf("v%0d_cmd_phase_miso", v), {24'd0, cmd_miso}, 32'd0);
            check($sformatf("v%0d_done_pulses", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("v%0d_err_pulses", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_err_at_8th_edge", v), err8, vecs[v].exp_err8);
            check($sformatf("v%0d_cmd_ch", v), {30'd0, cmd_ch}, {30'd0, vecs[v].exp_ch});
            check($sformatf("v%0d_busy_mid", v), {31'd0, busy_mid}, 32'd1);
            check($sformatf("v%0d_busy_after", v), {31'd0, busy}, 32'd0);
        end

        // Frame coherency: a load during DATA must not disturb the current frame.
        fork
            spi_frame(8'h80, 24, 1'b0, '0, data, cmd_miso, extra_nz, err8, busy_mid);
            begin
                #1200;
                load_all({sd[63:16], 16'hFFFF});
            end
        join
        check("coherent_old_sample", {16'd0, data}, 32'h1234);
        spi_frame(8'h80, 24, 1'b0, '0, data, cmd_miso, extra_nz, err8, busy_mid);
        check("coherent_new_sample", {16'd0, data}, 32'hFFFF);

        // Load in the same cycle as the detected cs_n falling edge.
        spi_frame(8'h81, 24, 1'b1, {sd[63:32], 16'hBEEF, 16'hFFFF}, data, cmd_miso, extra_nz, err8, busy_mid);
        check("coincident_load_sample", {16'd0, data}, 32'hBEEF);
        check("coincident_cmd_ch", {30'd0, cmd_ch}, 32'd1);

        // Reset mid-DATA with cs_n held low.
        @(negedge clk_100mhz);
        spi_cs_n = 1'b0;
        #50;
        for (int i = 0; i < 12; i++) begin
            spi_mosi = (i == 0 || i == 6) ? 1'b1 : 1'b0;
            #50 spi_sck = 1'b1;
            #50 spi_sck = 1'b0;
        end
        rst_n = 1'b0;
        #30;
        check("midreset_miso", {31'd0, spi_miso}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_cmd_ch", {30'd0, cmd_ch}, 32'd0);
        check("midreset_done", {31'd0, frame_done}, 32'd0);
        #20;
        rst_n = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        any_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'b1;
            #50 spi_sck = 1'b1;
            any_busy = any_busy | busy;
            #50 spi_sck = 1'b0;
            any_busy = any_busy | busy;
        end
        #50;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #300;
        check("postreset_ignored_busy", {31'd0, any_busy}, 32'd0);
        check("postreset_done_pulses", done_cnt - d0, 32'd0);
        check("postreset_err_pulses", err_cnt - e0, 32'd0);
        load_all(sd);
        d0 = done_cnt;
        spi_frame(8'h82, 24, 1'b0, '0, data, cmd_miso, extra_nz, err8, busy_mid);
        check("postreset_frame_data", {16'd0, data}, 32'hA5C3);
        check("postreset_frame_done", done_cnt - d0, 32'd1);
        check("postreset_cmd_ch", {30'd0, cmd_ch}, 32'd2);

        check("done_busy_overlap", {31'd0, done_busy_overlap}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
